// File: rtl/firebird7_in_gate1_tessent_mux_ovr_ctrl_pkg.sv
// Shared types and default constants for the IJTAG mux override controller.
package firebird7_in_gate1_tessent_mux_ovr_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      ACTIVE  = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam int DEF_DATA_W      = 19;
   localparam int DEF_SETTLE_CYC  = 4;
   localparam int DEF_TIMEOUT_CYC = 1024;
   localparam int GUARD_W         = 4;
   localparam int TIMEOUT_W       = 16;

endpackage

// File: rtl/firebird7_in_gate1_tessent_mux_ovr_tdr.sv
// Override TDR: capture/shift/update chain plus the pending register
// that hands updates to the override FSM.
module firebird7_in_gate1_tessent_mux_ovr_tdr
   import firebird7_in_gate1_tessent_mux_ovr_ctrl_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel,
   input  logic              ce,
   input  logic              se,
   input  logic              ue,
   input  logic              si,
   output logic              so,
   input  logic [DATA_W-1:0] func_data,
   input  logic              active,
   input  logic              consume,
   input  logic              clr_req,
   output logic              pend_req,
   output logic [DATA_W-1:0] pend_data,
   output logic              pend_valid
);

   logic [DATA_W:0] sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= '0;
      end else if (sel && ce) begin
         sr <= {active, func_data};
      end else if (sel && se) begin
         sr <= {si, sr[DATA_W:1]};
      end
   end

   // pend_valid/consume: the FSM takes {pend_req, pend_data} in a cycle where
   // pend_valid is high and pulses consume; an update in that same cycle wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_req   <= 1'b0;
         pend_data  <= '0;
         pend_valid <= 1'b0;
      end else if (sel && ue) begin
         pend_req   <= sr[DATA_W];
         pend_data  <= sr[DATA_W-1:0];
         pend_valid <= 1'b1;
      end else begin
         if (consume) pend_valid <= 1'b0;
         if (clr_req) pend_req   <= 1'b0;
      end
   end

   assign so = sr[0];

endmodule

// File: rtl/firebird7_in_gate1_tessent_mux_ovr_ctrl.sv
// IJTAG-driven override of a functional mux with settle guards around select.
// Optional auto-release timeout: FIREBIRD7_IN_GATE1_MUX_OVR_TIMEOUT_EN.
module firebird7_in_gate1_tessent_mux_ovr_ctrl
   import firebird7_in_gate1_tessent_mux_ovr_ctrl_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic              ijtag_tck,
   input  logic              ijtag_reset,
   input  logic              ijtag_sel,
   input  logic              ijtag_ce,
   input  logic              ijtag_se,
   input  logic              ijtag_ue,
   input  logic              ijtag_si,
   output logic              ijtag_so,
   input  logic [DATA_W-1:0] functional_data_in,
   output logic              ijtag_select,
   output logic [DATA_W-1:0] ijtag_data_out,
   output logic              ovr_active,
   output state_t            dbg_state
);

   localparam logic [GUARD_W-1:0] SETTLE_LAST = GUARD_W'(SETTLE_CYC - 1);

   if (SETTLE_CYC < 1 || SETTLE_CYC > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65536) begin : g_bad_param
      $error("firebird7 mux override: SETTLE_CYC or TIMEOUT_CYC out of range");
   end

   state_t              state, nxt;
   logic [GUARD_W-1:0]  cnt, cnt_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                sel_q, sel_d;
   logic                consume, clr_req;
   logic                pend_req, pend_valid;
   logic [DATA_W-1:0]   pend_data;

`ifdef FIREBIRD7_IN_GATE1_MUX_OVR_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
   logic [TIMEOUT_W-1:0] to_cnt, to_d;

   always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
      if (ijtag_reset) to_cnt <= '0;
      else             to_cnt <= to_d;
   end
`endif

   firebird7_in_gate1_tessent_mux_ovr_tdr #(.DATA_W(DATA_W)) u_tdr (
      .clk        (ijtag_tck),
      .rst        (ijtag_reset),
      .sel        (ijtag_sel),
      .ce         (ijtag_ce),
      .se         (ijtag_se),
      .ue         (ijtag_ue),
      .si         (ijtag_si),
      .so         (ijtag_so),
      .func_data  (functional_data_in),
      .active     (ovr_active),
      .consume    (consume),
      .clr_req    (clr_req),
      .pend_req   (pend_req),
      .pend_data  (pend_data),
      .pend_valid (pend_valid)
   );

   always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
      if (ijtag_reset) begin
         state  <= IDLE;
         cnt    <= '0;
         data_q <= '0;
         sel_q  <= 1'b0;
      end else begin
         state  <= nxt;
         cnt    <= cnt_d;
         data_q <= data_d;
         sel_q  <= sel_d;
      end
   end

   always_comb begin
      nxt     = state;
      cnt_d   = cnt;
      data_d  = data_q;
      consume = 1'b0;
      clr_req = 1'b0;
`ifdef FIREBIRD7_IN_GATE1_MUX_OVR_TIMEOUT_EN
      to_d    = to_cnt;
`endif
      case (state)
         IDLE: begin
            if (pend_valid) begin
               data_d  = pend_data;
               consume = 1'b1;
            end
            if (pend_req) begin
               nxt   = ARM;
               cnt_d = '0;
            end
         end
         ARM: begin
            if (cnt == SETTLE_LAST) begin
               nxt = ACTIVE;
`ifdef FIREBIRD7_IN_GATE1_MUX_OVR_TIMEOUT_EN
               to_d = '0;
`endif
            end else begin
               cnt_d = cnt + GUARD_W'(1);
            end
         end
         ACTIVE: begin
            if (pend_valid) begin
               data_d  = pend_data;
               consume = 1'b1;
`ifdef FIREBIRD7_IN_GATE1_MUX_OVR_TIMEOUT_EN
               to_d    = '0;
`endif
               if (!pend_req) begin
                  nxt   = RELEASE;
                  cnt_d = '0;
               end
            end
`ifdef FIREBIRD7_IN_GATE1_MUX_OVR_TIMEOUT_EN
            else if (to_cnt == TIMEOUT_LAST) begin
               nxt     = RELEASE;
               cnt_d   = '0;
               clr_req = 1'b1;
            end else begin
               to_d = to_cnt + TIMEOUT_W'(1);
            end
`endif
         end
         RELEASE: begin
            if (cnt == SETTLE_LAST) nxt = IDLE;
            else                    cnt_d = cnt + GUARD_W'(1);
         end
         default: nxt = IDLE;
      endcase
      // Select follows ACTIVE one cycle late on entry but drops with the exit edge.
      sel_d = (state == ACTIVE) && (nxt == ACTIVE);
   end

   assign ijtag_select   = sel_q;
   assign ijtag_data_out = data_q;
   assign ovr_active     = (state == ACTIVE);
   assign dbg_state      = state;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_mux_ovr_ctrl.sv
// Bench for the IJTAG mux override controller: directed table, corner sequences,
// and randomized scan traffic against a cycle model of the override rules.
module tb_firebird7_in_gate1_tessent_mux_ovr_ctrl;
   import firebird7_in_gate1_tessent_mux_ovr_ctrl_pkg::*;

   localparam int W      = 19;
   localparam int SETTLE = 4;
`ifdef FIREBIRD7_IN_GATE1_MUX_OVR_TIMEOUT_EN
   localparam int TOUT       = 8;
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam int TOUT       = 1024;
   localparam bit TIMEOUT_ON = 1'b0;
`endif
   localparam int M_OFF = 0, M_ARMING = 1, M_ON = 2, M_RELEASING = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         ijtag_sel = 1'b0, ijtag_ce = 1'b0, ijtag_se = 1'b0, ijtag_ue = 1'b0, ijtag_si = 1'b0;
   logic         ijtag_so;
   logic [W-1:0] functional_data_in = '0;
   logic         ijtag_select;
   logic [W-1:0] ijtag_data_out;
   logic         ovr_active;
   state_t       dbg_state;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   firebird7_in_gate1_tessent_mux_ovr_ctrl #(
      .DATA_W(W), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TOUT)
   ) u_dut (
      .ijtag_tck          (clk),
      .ijtag_reset        (rst),
      .ijtag_sel          (ijtag_sel),
      .ijtag_ce           (ijtag_ce),
      .ijtag_se           (ijtag_se),
      .ijtag_ue           (ijtag_ue),
      .ijtag_si           (ijtag_si),
      .ijtag_so           (ijtag_so),
      .functional_data_in (functional_data_in),
      .ijtag_select       (ijtag_select),
      .ijtag_data_out     (ijtag_data_out),
      .ovr_active         (ovr_active),
      .dbg_state          (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int           n_tests = 0;
   int           n_fail  = 0;
   logic [W:0]   exp_q[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [W:0]   m_sr;
   logic [W-1:0] m_pdata, m_data;
   logic         m_pv, m_req, m_sel;
   int           m_mode, m_left, m_on_cnt;

   task automatic model_reset();
      m_sr = '0; m_pdata = '0; m_data = '0;
      m_pv = 1'b0; m_req = 1'b0; m_sel = 1'b0;
      m_mode = M_OFF; m_left = 0; m_on_cnt = 0;
   endtask

   task automatic model_step();
      logic upd, cap, shf;
      bit   consumed, clr;
      int   old;
      upd = ijtag_sel && ijtag_ue;
      cap = ijtag_sel && ijtag_ce;
      shf = ijtag_sel && ijtag_se && !ijtag_ce;
      consumed = 0; clr = 0; old = m_mode;
      case (m_mode)
         M_OFF: begin
            if (m_pv) begin m_data = m_pdata; consumed = 1; end
            if (m_req) begin m_mode = M_ARMING; m_left = SETTLE; end
         end
         M_ARMING: begin
            m_left--;
            if (m_left == 0) begin m_mode = M_ON; m_on_cnt = 0; end
         end
         M_ON: begin
            if (m_pv) begin
               m_data = m_pdata; consumed = 1; m_on_cnt = 0;
               if (!m_req) begin m_mode = M_RELEASING; m_left = SETTLE; end
            end else if (TIMEOUT_ON && m_on_cnt == TOUT - 1) begin
               m_mode = M_RELEASING; m_left = SETTLE; clr = 1;
            end else begin
               m_on_cnt++;
            end
         end
         default: begin
            m_left--;
            if (m_left == 0) m_mode = M_OFF;
         end
      endcase
      m_sel = (old == M_ON) && (m_mode == M_ON);
      if (upd) begin
         m_pdata = m_sr[W-1:0]; m_req = m_sr[W]; m_pv = 1'b1;
      end else begin
         if (consumed) m_pv = 1'b0;
         if (clr) m_req = 1'b0;
      end
      if (cap)      m_sr = {(old == M_ON), functional_data_in};
      else if (shf) m_sr = {ijtag_si, m_sr[W:1]};
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input logic s, input logic ce, input logic se, input logic ue,
                       input logic si, input logic [W-1:0] f);
      ijtag_sel = s; ijtag_ce = ce; ijtag_se = se; ijtag_ue = ue; ijtag_si = si;
      functional_data_in = f;
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("model_sel",    ijtag_select,   m_sel);
      chk("model_data",   ijtag_data_out, m_data);
      chk("model_active", ovr_active,     (m_mode == M_ON));
      chk("model_so",     ijtag_so,       m_sr[0]);
   endtask

   task automatic idle();
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic shift_word(input logic [W:0] w);
      for (int i = 0; i <= W; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, w[i], '0);
   endtask

   task automatic update();
      tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
   endtask

   // Asserts reset between clock edges and checks the asynchronous clear.
   task automatic do_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      chk({tag, "_sel"},   ijtag_select,   0);
      chk({tag, "_data"},  ijtag_data_out, 0);
      chk({tag, "_so"},    ijtag_so,       0);
      chk({tag, "_act"},   ovr_active,     0);
      chk({tag, "_state"}, dbg_state,      IDLE);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk({tag, "_state_after"}, dbg_state, IDLE);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [W:0]   word;
      int           gap;
      logic         exp_sel;
      logic [W-1:0] exp_data;
      logic         exp_act;
   } vec_t;
   vec_t vecs[10];

   initial begin
      logic [W:0] got;

      vecs[0] = '{{1'b1, 19'h5A5A5}, 10, 1'b1, 19'h5A5A5, 1'b1};
      vecs[1] = '{{1'b1, 19'h00ABC}, 10, 1'b1, 19'h00ABC, 1'b1};
      vecs[2] = '{{1'b0, 19'h11111}, 10, 1'b0, 19'h11111, 1'b0};
      vecs[3] = '{{1'b0, 19'h22222}, 10, 1'b0, 19'h22222, 1'b0};
      vecs[4] = '{{1'b1, 19'h7FFFF}, 10, 1'b1, 19'h7FFFF, 1'b1};
      vecs[5] = '{{1'b1, 19'h00000},  2, 1'b1, 19'h00000, 1'b1};
      vecs[6] = '{{1'b0, 19'h3C3C3},  3, 1'b0, 19'h3C3C3, 1'b0};
      vecs[7] = '{{1'b1, 19'h0F0F0},  5, 1'b0, 19'h0F0F0, 1'b1};
      vecs[8] = '{{1'b1, 19'h00001},  0, 1'b1, 19'h0F0F0, 1'b1};
      vecs[9] = '{{1'b0, 19'h55555},  1, 1'b0, 19'h55555, 1'b0};

      model_reset();
      do_reset("init_rst");

`ifndef FIREBIRD7_IN_GATE1_MUX_OVR_TIMEOUT_EN
      for (int v = 0; v < 10; v++) begin
         shift_word(vecs[v].word);
         update();
         for (int g = 0; g < vecs[v].gap; g++) idle();
         chk($sformatf("tbl%0d_sel", v),  ijtag_select,   vecs[v].exp_sel);
         chk($sformatf("tbl%0d_data", v), ijtag_data_out, vecs[v].exp_data);
         chk($sformatf("tbl%0d_act", v),  ovr_active,     vecs[v].exp_act);
      end
`endif

      // Entry latency from IDLE.
      do_reset("pre033_rst");
      shift_word({1'b1, 19'h5A5A5});
      update();
      idle();
      chk("r033_data", ijtag_data_out, 19'h5A5A5);
      chk("r033_sel_e1", ijtag_select, 0);
      for (int k = 2; k <= 5; k++) begin
         idle();
         chk($sformatf("r033_sel_e%0d", k), ijtag_select, 0);
      end
      idle();
      chk("r033_sel_rise", ijtag_select, 1);
      chk("r033_act", ovr_active, 1);

`ifndef FIREBIRD7_IN_GATE1_MUX_OVR_TIMEOUT_EN
      // Capture in ACTIVE and stream out LSB-first.
      exp_q.push_back({1'b1, 19'h12345});
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 19'h12345);
      got[0] = ijtag_so;
      for (int i = 1; i <= W; i++) begin
         tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
         got[i] = ijtag_so;
      end
      chk("r034_so_stream", got, exp_q.pop_front());

      // Release from ACTIVE with a req=0 update.
      shift_word('0);
      update();
      chk("r035_sel_hold", ijtag_select, 1);
      idle();
      chk("r035_sel_fall", ijtag_select, 0);
      chk("r035_data", ijtag_data_out, 0);
      for (int k = 0; k < 3; k++) idle();
      chk("r035_release", dbg_state, RELEASE);
      idle();
      chk("r035_idle", dbg_state, IDLE);

      // Two updates during ARM: only the last is applied on entering ACTIVE.
      shift_word({1'b1, 19'h00006});
      update();
      tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0);
      chk("r036_data_e1", ijtag_data_out, 19'h00006);
      chk("r036_arm", dbg_state, ARM);
      update();
      tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0);
      update();
      chk("r036_data_e4", ijtag_data_out, 19'h00006);
      idle();
      chk("r036_data_e5", ijtag_data_out, 19'h00006);
      chk("r036_active", ovr_active, 1);
      idle();
      chk("r036_data_last", ijtag_data_out, 19'h60001);

      // Asynchronous reset while ACTIVE.
      shift_word(20'h00001);
      chk("r037_pre_so", ijtag_so, 1);
      chk("r037_pre_sel", ijtag_select, 1);
      do_reset("r037");
      idle();
      chk("r037_sel_after", ijtag_select, 0);
`else
      // Auto-release after TOUT ACTIVE cycles with no further updates.
      begin
         int act_cycles;
         act_cycles = 1;
         for (int k = 0; k < 40; k++) begin
            idle();
            if (ovr_active) act_cycles++;
         end
         chk("r038_active_cycles", act_cycles, TOUT);
         chk("r038_sel_low", ijtag_select, 0);
         tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 19'h1);
         for (int i = 0; i < W; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
         chk("r038_cap_active", ijtag_so, 0);
      end
`endif

      // Randomized scan traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         if (i == 1000) do_reset("rnd_rst");
         tick(($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0),
              1'($urandom_range(0, 1)), W'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
